// File: rtl/fdiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : fdiv_iter
// Purpose  : Multi-cycle floating-point divider y = x1 / x2 with valid/ready
//            handshakes, restoring division (R quotient bits per cycle),
//            round-to-nearest-even, denormal flush and special operands.
// Options  : define FDIV_FLAGS_EN to add the flags[3:0] output
//            {invalid, divzero, overflow, inexact}.
// Revision : 1.0 - initial release
// ============================================================================
module fdiv_iter #(
  parameter int EW = 8,   // exponent width
  parameter int MW = 23,  // stored mantissa width
  parameter int R  = 1    // quotient bits per DIV cycle (1 or 2)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic             ovf,
  output logic             busy
`ifdef FDIV_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int W  = 1 + EW + MW;
  localparam int NQ = MW + 4;              // quotient bits: 1 integer + MW + guard + 2 extra
  localparam int CW = $clog2(NQ + 1) + 1;  // quotient bit counter width

  localparam logic [CW-1:0] NQ_C    = CW'(NQ);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [EW+1:0] BIAS_V  = (EW+2)'((1 << (EW - 1)) - 1);
  localparam logic [EW+1:0] E_ONE   = (EW+2)'(1);
  localparam logic [EW:0]   EMAX_V  = (EW+1)'((1 << EW) - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_DIV  = 3'd2,
    S_NORM = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x1_q, x1_d, x2_q, x2_d;
  logic            sign_q, sign_d;
  logic [EW+1:0]   exp_q, exp_d;
  logic [MW+1:0]   rem_q, rem_d;
  logic [MW:0]     div_q, div_d;
  logic [NQ-1:0]   quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    y_q, y_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
`ifdef FDIV_FLAGS_EN
  logic [3:0]      flags_q, flags_d;
`endif

  // Operand fields of the captured operands
  logic            s1, s2;
  logic [EW-1:0]   e1, e2;
  logic [MW-1:0]   m1, m2;
  logic            z1, z2, i1, i2;

  // Unpack the registered operands and classify them
  always_comb begin
    s1 = x1_q[W-1];
    s2 = x2_q[W-1];
    e1 = x1_q[W-2 -: EW];
    e2 = x2_q[W-2 -: EW];
    m1 = x1_q[MW-1:0];
    m2 = x2_q[MW-1:0];
    z1 = (e1 == '0);
    z2 = (e2 == '0);
    i1 = (e1 == '1);
    i2 = (e2 == '1);
  end

  // One DIV cycle: up to R restoring steps, stopping once NQ bits are retired
  logic [MW+1:0]   rem_t;
  logic [NQ-1:0]   quo_t;
  logic [CW-1:0]   cnt_t;
  always_comb begin
    rem_t = rem_q;
    quo_t = quo_q;
    cnt_t = cnt_q;
    for (int k = 0; k < R; k++) begin
      if (cnt_t < NQ_C) begin
        if (rem_t >= {1'b0, div_q}) begin
          rem_t = rem_t - {1'b0, div_q};
          quo_t = {quo_t[NQ-2:0], 1'b1};
        end else begin
          quo_t = {quo_t[NQ-2:0], 1'b0};
        end
        rem_t = rem_t << 1;
        cnt_t = cnt_t + CNT_ONE;
      end
    end
  end

  // Normalise, round to nearest even and range-check the quotient
  logic [NQ-1:0]   q_n;
  logic [EW+1:0]   e_n, e_r;
  logic [MW:0]     mant;
  logic            guard, sticky, rnd;
  logic [MW+1:0]   msum;
  logic [W-1:0]    norm_y;
  logic            norm_ovf;
  logic            norm_unf;
  always_comb begin
    q_n    = quo_q[NQ-1] ? quo_q : {quo_q[NQ-2:0], 1'b0};
    e_n    = quo_q[NQ-1] ? exp_q : (exp_q - E_ONE);
    mant   = q_n[NQ-1 -: MW+1];
    guard  = q_n[2];
    sticky = (|q_n[1:0]) | (|rem_q);
    rnd    = guard & (sticky | mant[0]);
    msum   = {1'b0, mant} + {{(MW+1){1'b0}}, rnd};
    // a carry out of the mantissa leaves 1.000..0, so only the exponent moves
    e_r    = e_n + {{(EW+1){1'b0}}, msum[MW+1]};
    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (!e_r[EW+1] && (e_r[EW:0] >= EMAX_V)) begin
      norm_y   = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
      norm_ovf = 1'b1;
    end else if (e_r[EW+1] || (e_r == '0)) begin
      norm_y   = {sign_q, {(W-1){1'b0}}};
      norm_unf = 1'b1;
    end else begin
      norm_y   = {sign_q, e_r[EW-1:0], msum[MW-1:0]};
    end
  end

  // Next-state and next-output logic for the control FSM and datapath
  always_comb begin
    state_d = state_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
`ifdef FDIV_FLAGS_EN
    flags_d = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x1_d    = x1;
          x2_d    = x2;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d = s1 ^ s2;
        if ((z1 && z2) || (i1 && i2)) begin
          // quiet NaN is always positive
          y_d     = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
          ovf_d   = 1'b0;
`ifdef FDIV_FLAGS_EN
          flags_d = 4'b1000;
`endif
          state_d = S_DONE;
        end else if (i1) begin
          // inf / finite (including zero) is an exact infinity
          y_d     = {s1 ^ s2, {EW{1'b1}}, {MW{1'b0}}};
          ovf_d   = 1'b1;
`ifdef FDIV_FLAGS_EN
          flags_d = 4'b0000;
`endif
          state_d = S_DONE;
        end else if (z2) begin
          y_d     = {s1 ^ s2, {EW{1'b1}}, {MW{1'b0}}};
          ovf_d   = 1'b1;
`ifdef FDIV_FLAGS_EN
          flags_d = 4'b0100;
`endif
          state_d = S_DONE;
        end else if (z1 || i2) begin
          y_d     = {s1 ^ s2, {(W-1){1'b0}}};
          ovf_d   = 1'b0;
`ifdef FDIV_FLAGS_EN
          flags_d = 4'b0000;
`endif
          state_d = S_DONE;
        end else begin
          rem_d   = {1'b0, 1'b1, m1};
          div_d   = {1'b1, m2};
          exp_d   = {2'b00, e1} - {2'b00, e2} + BIAS_V;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_t;
        quo_d = quo_t;
        cnt_d = cnt_t;
        if (cnt_t == NQ_C) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        y_d     = norm_y;
        ovf_d   = norm_ovf;
`ifdef FDIV_FLAGS_EN
        flags_d = {2'b00, norm_ovf, (guard | sticky) & (norm_unf | !norm_ovf)};
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      x1_q        <= '0;
      x2_q        <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef FDIV_FLAGS_EN
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef FDIV_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
`ifdef FDIV_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fdiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdiv_iter
// Purpose  : Directed and random self-checking bench for fdiv_iter
//            (single precision, R=1). Flag checks are enabled when
//            FDIV_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fdiv_iter;

  localparam int TB_R   = 1;
  localparam int NQ     = 27;
  localparam int EXP_LAT = 3 + (NQ + TB_R - 1) / TB_R;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1, x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        busy;
`ifdef FDIV_FLAGS_EN
  logic [3:0]  flags;
  logic [3:0]  r_flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fdiv_iter #(.EW(8), .MW(23), .R(TB_R)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .busy      (busy)
`ifdef FDIV_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // single -> double (normal inputs only)
  function automatic real f2d(input logic [31:0] f);
    logic [10:0] e;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  // double -> single with round-to-nearest-even (normal range only)
  function automatic logic [31:0] d2f(input real r);
    logic [63:0] b;
    logic [23:0] m;
    logic [24:0] ms;
    logic        g, st, rnd;
    int          e;
    b   = $realtobits(r);
    m   = {1'b1, b[51:29]};
    g   = b[28];
    st  = |b[27:0];
    rnd = g & (st | m[0]);
    ms  = {1'b0, m} + {24'd0, rnd};
    e   = int'(b[62:52]) - 896;
    if (ms[24]) begin
      e++;
      ms = ms >> 1;
    end
    return {b[63], e[7:0], ms[22:0]};
  endfunction

  // Issue one operation, wait for the result and complete the handshake
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] ry, output logic rovf, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) check_val("in_ready_timeout", 64'd0, 64'd1);
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x1 = $urandom;
    x2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check_val("out_valid_timeout", 64'd0, 64'd1);
    ry   = y;
    rovf = ovf;
`ifdef FDIV_FLAGS_EN
    r_flags = flags;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ey;
    logic        eovf;
    logic [3:0]  efl;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] ry, y0, a, b;
    logic        rovf, ok, saw;
    int          lat, g;

    vecs.push_back('{32'h40400000, 32'h3F800000, 32'h40400000, 1'b0, 4'b0000}); // 3/1
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 4'b0001}); // 1/3
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 4'b0100}); // 1/0
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 4'b1000}); // 0/0
    vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 4'b1000}); // inf/inf
    vecs.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 4'b0000}); // inf/1
    vecs.push_back('{32'h00000000, 32'h3F800000, 32'h00000000, 1'b0, 4'b0000}); // 0/1
    vecs.push_back('{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 4'b0000}); // 1/inf
    vecs.push_back('{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 4'b0100}); // -1/0
    vecs.push_back('{32'hC0400000, 32'h3F800000, 32'hC0400000, 1'b0, 4'b0000}); // -3/1
    vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 4'b0010}); // overflow
    vecs.push_back('{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 4'b0000}); // underflow
    vecs.push_back('{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0, 4'b0001}); // 2/3
    vecs.push_back('{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 4'b0100}); // 1/-0
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 4'b0000}); // denormal/1

    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x1        = '0;
    x2        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_y", {32'd0, y}, 64'd0);
    check_val("rst_ovf", {63'd0, ovf}, 64'd0);
    check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef FDIV_FLAGS_EN
    check_val("rst_flags", {60'd0, flags}, 64'd0);
`endif
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, ry, rovf, lat);
      check_val($sformatf("vec%0d_y", i), {32'd0, ry}, {32'd0, vecs[i].ey});
      check_val($sformatf("vec%0d_ovf", i), {63'd0, rovf}, {63'd0, vecs[i].eovf});
`ifdef FDIV_FLAGS_EN
      check_val($sformatf("vec%0d_flags", i), {60'd0, r_flags}, {60'd0, vecs[i].efl});
`endif
      if (i == 0) check_val("latency", 64'(lat), 64'(EXP_LAT));
    end

    // Backpressure: result held, in_ready low and in_valid ignored
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    x1 = 32'h40400000;
    x2 = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check_val("bp_out_valid", {63'd0, out_valid}, 64'd1);
    y0 = y;
    check_val("bp_y", {32'd0, y0}, 64'h40400000);
    in_valid = 1'b1;
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (y !== y0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    check_val("bp_stable", {63'd0, ok}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp_release_valid", {63'd0, out_valid}, 64'd0);
    check_val("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    check_val("bp_no_accept", {63'd0, busy}, 64'd0);

    // Reset in the middle of DIV aborts silently
    x1 = 32'h3F800000;
    x2 = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("mid_busy", {63'd0, busy}, 64'd1);
    rstn = 1'b0;
    #1;
    check_val("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check_val("arst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check_val("abort_no_valid", {63'd0, saw}, 64'd0);
    check_val("abort_in_ready", {63'd0, in_ready}, 64'd1);

    // Random normal operands against a double-precision reference
    for (int n = 0; n < 1000; n++) begin
      a = {1'($urandom), 8'($urandom_range(70, 180)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(70, 180)), 23'($urandom)};
      run_op(a, b, ry, rovf, lat);
      check_val($sformatf("rand %h/%h", a, b), {31'd0, rovf, ry}, {32'd0, d2f(f2d(a) / f2d(b))});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
